// File: rtl/decode_execute_latch.sv
// rtl/decode_execute_latch.sv - ID/EX pipeline register with bubble insertion, halt freeze and bubble counter
//
// Purpose: captures the decoded instruction, operands and control on each pipeline
// advance, loads a bubble when the hazard unit asks for a flush, and freezes once a
// HALT has reached EX. Counts inserted bubbles (saturating).
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   advance             pipeline moves this cycle; otherwise everything holds
//   dx_flush            load a bubble instead of the decode contents
//   dec_*               decoded instruction, operands and control from ID
//   ex_*                registered copies presented to EX and the hazard unit
//   ex_valid            1 = EX holds a real instruction, 0 = bubble
//   bubble_cnt          bubbles inserted since reset, saturating at all-ones
module decode_execute_latch #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             advance,
   input  logic             dx_flush,
   input  logic [31:0]      dec_instr,
   input  logic [31:0]      dec_npc,
   input  logic [31:0]      dec_rdat1,
   input  logic [31:0]      dec_rdat2,
   input  logic [31:0]      dec_imm,
   input  logic             dec_rfWEN,
   input  logic [4:0]       dec_dest,
   input  logic             dec_memREN,
   input  logic             dec_memWEN,
   input  logic [3:0]       dec_aluop,
   input  logic             dec_halt,
   output logic [31:0]      ex_reg,
   output logic [31:0]      ex_npc,
   output logic [31:0]      ex_rdat1,
   output logic [31:0]      ex_rdat2,
   output logic [31:0]      ex_imm,
   output logic             ex_rfWEN,
   output logic             ex_memREN,
   output logic             ex_memWEN,
   output logic             ex_halt,
   output logic [4:0]       ex_dest,
   output logic [3:0]       ex_aluop,
   output logic             ex_valid,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic [31:0]      ex_reg_q,   ex_reg_d;
   logic [31:0]      ex_npc_q,   ex_npc_d;
   logic [31:0]      ex_rdat1_q, ex_rdat1_d;
   logic [31:0]      ex_rdat2_q, ex_rdat2_d;
   logic [31:0]      ex_imm_q,   ex_imm_d;
   logic             ex_rfWEN_q, ex_rfWEN_d;
   logic             ex_memREN_q, ex_memREN_d;
   logic             ex_memWEN_q, ex_memWEN_d;
   logic             ex_halt_q,  ex_halt_d;
   logic [4:0]       ex_dest_q,  ex_dest_d;
   logic [3:0]       ex_aluop_q, ex_aluop_d;
   logic             ex_valid_q, ex_valid_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      ex_reg_d     = ex_reg_q;
      ex_npc_d     = ex_npc_q;
      ex_rdat1_d   = ex_rdat1_q;
      ex_rdat2_d   = ex_rdat2_q;
      ex_imm_d     = ex_imm_q;
      ex_rfWEN_d   = ex_rfWEN_q;
      ex_memREN_d  = ex_memREN_q;
      ex_memWEN_d  = ex_memWEN_q;
      ex_halt_d    = ex_halt_q;
      ex_dest_d    = ex_dest_q;
      ex_aluop_d   = ex_aluop_q;
      ex_valid_d   = ex_valid_q;
      bubble_cnt_d = bubble_cnt_q;

      // A halted EX stage ignores everything; a stalled pipe drops the flush
      // request rather than remembering it for later.
      if (!ex_halt_q && advance) begin
         if (dx_flush) begin
            ex_reg_d    = NOP_WORD;
            ex_npc_d    = '0;
            ex_rdat1_d  = '0;
            ex_rdat2_d  = '0;
            ex_imm_d    = '0;
            ex_rfWEN_d  = 1'b0;
            ex_memREN_d = 1'b0;
            ex_memWEN_d = 1'b0;
            ex_halt_d   = 1'b0;
            ex_dest_d   = '0;
            ex_aluop_d  = '0;
            ex_valid_d  = 1'b0;
            if (!(&bubble_cnt_q)) begin
               bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
         end else begin
            ex_reg_d    = dec_instr;
            ex_npc_d    = dec_npc;
            ex_rdat1_d  = dec_rdat1;
            ex_rdat2_d  = dec_rdat2;
            ex_imm_d    = dec_imm;
            // Writes to $zero never reach the hazard unit as a real write.
            ex_rfWEN_d  = dec_rfWEN & (dec_dest != 5'd0);
            ex_memREN_d = dec_memREN;
            ex_memWEN_d = dec_memWEN;
            ex_halt_d   = dec_halt;
            ex_dest_d   = dec_dest;
            ex_aluop_d  = dec_aluop;
            ex_valid_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_reg_q     <= NOP_WORD;
         ex_npc_q     <= '0;
         ex_rdat1_q   <= '0;
         ex_rdat2_q   <= '0;
         ex_imm_q     <= '0;
         ex_rfWEN_q   <= 1'b0;
         ex_memREN_q  <= 1'b0;
         ex_memWEN_q  <= 1'b0;
         ex_halt_q    <= 1'b0;
         ex_dest_q    <= '0;
         ex_aluop_q   <= '0;
         ex_valid_q   <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         ex_reg_q     <= ex_reg_d;
         ex_npc_q     <= ex_npc_d;
         ex_rdat1_q   <= ex_rdat1_d;
         ex_rdat2_q   <= ex_rdat2_d;
         ex_imm_q     <= ex_imm_d;
         ex_rfWEN_q   <= ex_rfWEN_d;
         ex_memREN_q  <= ex_memREN_d;
         ex_memWEN_q  <= ex_memWEN_d;
         ex_halt_q    <= ex_halt_d;
         ex_dest_q    <= ex_dest_d;
         ex_aluop_q   <= ex_aluop_d;
         ex_valid_q   <= ex_valid_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_reg     = ex_reg_q;
   assign ex_npc     = ex_npc_q;
   assign ex_rdat1   = ex_rdat1_q;
   assign ex_rdat2   = ex_rdat2_q;
   assign ex_imm     = ex_imm_q;
   assign ex_rfWEN   = ex_rfWEN_q;
   assign ex_memREN  = ex_memREN_q;
   assign ex_memWEN  = ex_memWEN_q;
   assign ex_halt    = ex_halt_q;
   assign ex_dest    = ex_dest_q;
   assign ex_aluop   = ex_aluop_q;
   assign ex_valid   = ex_valid_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_decode_execute_latch.sv
// tb/tb_decode_execute_latch.sv - self-checking bench for decode_execute_latch
module tb_decode_execute_latch;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam int          CW  = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          advance = 1'b0, dx_flush = 1'b0;
   logic [31:0]   dec_instr = '0, dec_npc = '0, dec_rdat1 = '0, dec_rdat2 = '0, dec_imm = '0;
   logic          dec_rfWEN = 1'b0, dec_memREN = 1'b0, dec_memWEN = 1'b0, dec_halt = 1'b0;
   logic [4:0]    dec_dest = '0;
   logic [3:0]    dec_aluop = '0;
   logic [31:0]   ex_reg, ex_npc, ex_rdat1, ex_rdat2, ex_imm;
   logic          ex_rfWEN, ex_memREN, ex_memWEN, ex_halt, ex_valid;
   logic [4:0]    ex_dest;
   logic [3:0]    ex_aluop;
   logic [CW-1:0] bubble_cnt;

   decode_execute_latch #(.NOP_WORD(NOP), .CNT_W(CW)) dut (
      .CLK(CLK), .RST(RST), .advance(advance), .dx_flush(dx_flush),
      .dec_instr(dec_instr), .dec_npc(dec_npc), .dec_rdat1(dec_rdat1),
      .dec_rdat2(dec_rdat2), .dec_imm(dec_imm), .dec_rfWEN(dec_rfWEN),
      .dec_dest(dec_dest), .dec_memREN(dec_memREN), .dec_memWEN(dec_memWEN),
      .dec_aluop(dec_aluop), .dec_halt(dec_halt),
      .ex_reg(ex_reg), .ex_npc(ex_npc), .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2),
      .ex_imm(ex_imm), .ex_rfWEN(ex_rfWEN), .ex_memREN(ex_memREN),
      .ex_memWEN(ex_memWEN), .ex_halt(ex_halt), .ex_dest(ex_dest),
      .ex_aluop(ex_aluop), .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
   );

   always #5 CLK = ~CLK;

   // Expected architectural content of the EX stage.
   typedef struct {
      logic [31:0] instr, npc, r1, r2, imm;
      logic        rfwen, memren, memwen, halt, valid;
      logic [4:0]  dest;
      logic [3:0]  aluop;
      int          bubbles;
   } ex_t;

   typedef struct {
      logic        adv, flush;
      logic [31:0] instr;
      logic [4:0]  dest;
      logic        rfwen;
      logic [31:0] e_reg;
      logic [4:0]  e_dest;
      logic        e_rfwen, e_valid;
      logic [3:0]  e_cnt;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   ex_t  m;

   function automatic ex_t empty_stage(int bubbles);
      ex_t s;
      s.instr = NOP; s.npc = 0; s.r1 = 0; s.r2 = 0; s.imm = 0;
      s.rfwen = 0; s.memren = 0; s.memwen = 0; s.halt = 0; s.valid = 0;
      s.dest = 0; s.aluop = 0; s.bubbles = bubbles;
      return s;
   endfunction

   // One rising edge of the stage, stated directly from the pipeline rules.
   function automatic ex_t next_stage(ex_t s);
      ex_t n;
      if (s.halt || !advance) return s;
      if (dx_flush) begin
         n = empty_stage(s.bubbles < (1 << CW) - 1 ? s.bubbles + 1 : s.bubbles);
         return n;
      end
      n.instr = dec_instr; n.npc = dec_npc; n.r1 = dec_rdat1; n.r2 = dec_rdat2;
      n.imm = dec_imm; n.memren = dec_memREN; n.memwen = dec_memWEN;
      n.halt = dec_halt; n.dest = dec_dest; n.aluop = dec_aluop; n.valid = 1;
      n.rfwen = dec_rfWEN && dec_dest != 0;
      n.bubbles = s.bubbles;
      return n;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(string tag);
      chk({tag, ".ex_reg"},    ex_reg,    m.instr);
      chk({tag, ".ex_npc"},    ex_npc,    m.npc);
      chk({tag, ".ex_rdat1"},  ex_rdat1,  m.r1);
      chk({tag, ".ex_rdat2"},  ex_rdat2,  m.r2);
      chk({tag, ".ex_imm"},    ex_imm,    m.imm);
      chk({tag, ".ex_rfWEN"},  {31'd0, ex_rfWEN},  {31'd0, m.rfwen});
      chk({tag, ".ex_memREN"}, {31'd0, ex_memREN}, {31'd0, m.memren});
      chk({tag, ".ex_memWEN"}, {31'd0, ex_memWEN}, {31'd0, m.memwen});
      chk({tag, ".ex_halt"},   {31'd0, ex_halt},   {31'd0, m.halt});
      chk({tag, ".ex_valid"},  {31'd0, ex_valid},  {31'd0, m.valid});
      chk({tag, ".ex_dest"},   {27'd0, ex_dest},   {27'd0, m.dest});
      chk({tag, ".ex_aluop"},  {28'd0, ex_aluop},  {28'd0, m.aluop});
      chk({tag, ".bubble_cnt"}, {28'd0, bubble_cnt}, m.bubbles);
   endtask

   task automatic rand_dec();
      dec_instr = $urandom; dec_npc = $urandom; dec_rdat1 = $urandom;
      dec_rdat2 = $urandom; dec_imm = $urandom;
      dec_rfWEN = 1'($urandom); dec_memREN = 1'($urandom); dec_memWEN = 1'($urandom);
      dec_dest = 5'($urandom % 4 == 0 ? 0 : $urandom); dec_aluop = 4'($urandom);
      dec_halt = 1'b0;
   endtask

   // Inputs are already set; take one edge and compare #1 after it.
   task automatic step(string tag);
      ex_t nm;
      @(posedge CLK);
      nm = next_stage(m);
      m = nm;
      #1;
      chk_all(tag);
   endtask

   // Asynchronous reset raised between edges must clear outputs before the next edge.
   task automatic async_reset(string tag);
      RST = 1'b1;
      #1;
      m = empty_stage(0);
      chk_all(tag);
      RST = 1'b0;
   endtask

   vec_t vt[8];

   initial begin
      vt[0] = '{1, 0, 32'h8C22_0004, 5'd2,  1, 32'h8C22_0004, 5'd2,  1, 1, 4'd0};
      vt[1] = '{1, 1, 32'h1111_1111, 5'd7,  1, NOP,           5'd0,  0, 0, 4'd1};
      vt[2] = '{1, 1, 32'h2222_2222, 5'd8,  1, NOP,           5'd0,  0, 0, 4'd2};
      vt[3] = '{1, 1, 32'h3333_3333, 5'd9,  1, NOP,           5'd0,  0, 0, 4'd3};
      vt[4] = '{1, 0, 32'h0000_0020, 5'd0,  1, 32'h0000_0020, 5'd0,  0, 1, 4'd3};
      vt[5] = '{0, 1, 32'hDEAD_BEEF, 5'd4,  1, 32'h0000_0020, 5'd0,  0, 1, 4'd3};
      vt[6] = '{1, 0, 32'h1234_5678, 5'd31, 0, 32'h1234_5678, 5'd31, 0, 1, 4'd3};
      vt[7] = '{1, 0, 32'hAABB_CCDD, 5'd5,  1, 32'hAABB_CCDD, 5'd5,  1, 1, 4'd3};

      m = empty_stage(0);
      #12;
      chk_all("reset");
      RST = 1'b0;

      // Table-driven vectors from reset.
      for (int i = 0; i < 8; i++) begin
         advance = vt[i].adv; dx_flush = vt[i].flush; dec_instr = vt[i].instr;
         dec_dest = vt[i].dest; dec_rfWEN = vt[i].rfwen;
         @(posedge CLK);
         #1;
         chk($sformatf("vec%0d.ex_reg", i),   ex_reg, vt[i].e_reg);
         chk($sformatf("vec%0d.ex_dest", i),  {27'd0, ex_dest}, {27'd0, vt[i].e_dest});
         chk($sformatf("vec%0d.ex_rfWEN", i), {31'd0, ex_rfWEN}, {31'd0, vt[i].e_rfwen});
         chk($sformatf("vec%0d.ex_valid", i), {31'd0, ex_valid}, {31'd0, vt[i].e_valid});
         chk($sformatf("vec%0d.bubble_cnt", i), {28'd0, bubble_cnt}, {28'd0, vt[i].e_cnt});
      end

      // Mid-stream reset discards the held instruction.
      async_reset("midreset");

      // Stall: load A, then advance=0 with dx_flush=1 for 4 cycles.
      @(negedge CLK);
      advance = 1; dx_flush = 0; rand_dec(); dec_instr = 32'hA5A5_0001;
      dec_memREN = 1; dec_memWEN = 1;
      step("loadA");
      chk("loadA.illegal_both", {30'd0, ex_memREN, ex_memWEN}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         advance = 0; dx_flush = 1; rand_dec();
         step($sformatf("stall%0d", i));
      end
      chk("stall.keepA", ex_reg, 32'hA5A5_0001);
      chk("stall.cnt", {28'd0, bubble_cnt}, 32'd0);

      // Saturation: 20 flushes on a 4-bit counter, then HALT freezes the stage.
      async_reset("satreset");
      for (int i = 0; i < 20; i++) begin
         advance = 1; dx_flush = 1; rand_dec();
         step("flushrun");
      end
      chk("sat.cnt", {28'd0, bubble_cnt}, 32'h0000_000F);
      advance = 1; dx_flush = 0; rand_dec(); dec_halt = 1; dec_instr = 32'hFFFF_FFFF;
      step("halt");
      chk("halt.ex_halt", {31'd0, ex_halt}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         advance = 1; dx_flush = 1'(i % 2); rand_dec();
         step("halted");
      end
      chk("halted.reg", ex_reg, 32'hFFFF_FFFF);
      async_reset("haltreset");

      // Randomized run against the model, with occasional halts and resets.
      for (int c = 0; c < 400; c++) begin
         advance = ($urandom % 4) != 0;
         dx_flush = ($urandom % 3) == 0;
         rand_dec();
         dec_halt = ($urandom % 60) == 0;
         step("rand");
         if (c % 50 == 49) async_reset("randreset");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
